// File: rtl/demod_frame_scheduler_if.sv
// rtl/demod_frame_scheduler_if.sv - bus bundle between scheduler, sample source, segment array and bit sink
//
// Purpose: groups the frame-request, sample-load, segment issue/result and frame-output
// signals of demod_frame_scheduler.
// Modports:
//   master - the scheduler: drives in_ready, seg_start/seg_index/seg_data,
//            frame_bits/frame_valid, busy, timeout_err
//   slave  - the environment: drives start, in_valid/in_data, seg_result/seg_valid
interface demod_frame_scheduler_if #(
   parameter int NSEG  = 10,
   parameter int WIDTH = 32
);
   logic             start;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             seg_start;
   logic [3:0]       seg_index;
   logic [WIDTH-1:0] seg_data;
   logic [WIDTH-1:0] seg_result;
   logic             seg_valid;
   logic [NSEG-1:0]  frame_bits;
   logic             frame_valid;
   logic             busy;
   logic             timeout_err;

   modport master (
      input  start, in_valid, in_data, seg_result, seg_valid,
      output in_ready, seg_start, seg_index, seg_data,
             frame_bits, frame_valid, busy, timeout_err
   );

   modport slave (
      output start, in_valid, in_data, seg_result, seg_valid,
      input  in_ready, seg_start, seg_index, seg_data,
             frame_bits, frame_valid, busy, timeout_err
   );
endinterface

// File: rtl/demod_frame_scheduler.sv
// rtl/demod_frame_scheduler.sv - sequences one frame of soft samples through the shared segment datapath
//
// Purpose: buffers NSEG Q16.16 samples, issues each to the segment datapath in slot
// order, waits (bounded by TIMEOUT) for each result and slices it to a hard bit.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - demod_frame_scheduler_if.master:
//            start, in_valid, in_data, in_ready     : frame request and sample load
//            seg_start, seg_index, seg_data         : slot issue to the segment datapath
//            seg_result, seg_valid                  : segment answer
//            frame_bits, frame_valid                : packed frame decision
//            busy, timeout_err                      : status
module demod_frame_scheduler #(
   parameter int NSEG    = 10,
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   demod_frame_scheduler_if.master  bus
);

   localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam int WW = $clog2(TIMEOUT);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NSEG - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    load_cnt_q, load_cnt_d;
   logic [IW-1:0]    slot_q, slot_d;
   logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
   logic [NSEG-1:0]  bits_q, bits_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] buf_q [NSEG];
   logic [WIDTH-1:0] buf_d [NSEG];
   logic             advance;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         load_cnt_q <= '0;
         slot_q     <= '0;
         wait_cnt_q <= '0;
         bits_q     <= '0;
         err_q      <= 1'b0;
         for (int i = 0; i < NSEG; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         load_cnt_q <= load_cnt_d;
         slot_q     <= slot_d;
         wait_cnt_q <= wait_cnt_d;
         bits_q     <= bits_d;
         err_q      <= err_d;
         buf_q      <= buf_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_cnt_d = load_cnt_q;
      slot_d     = slot_q;
      wait_cnt_d = wait_cnt_q;
      bits_d     = bits_q;
      err_d      = err_q;
      buf_d      = buf_q;
      advance    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d    = S_LOAD;
               load_cnt_d = '0;
               err_d      = 1'b0;
               bits_d     = '0;
            end
         end

         S_LOAD: begin
            if (bus.in_valid) begin
               buf_d[load_cnt_q] = bus.in_data;
               load_cnt_d        = load_cnt_q + 1'b1;
               if (load_cnt_q == LAST_IDX) begin
                  state_d = S_ISSUE;
                  slot_d  = '0;
               end
            end
         end

         S_ISSUE: begin
            state_d    = S_WAIT;
            wait_cnt_d = '0;
         end

         S_WAIT: begin
            // A result arriving in the final wait cycle takes priority over the timeout.
            if (bus.seg_valid) begin
               bits_d[slot_q] = ~bus.seg_result[WIDTH-1];
               advance        = 1'b1;
            end else if (wait_cnt_q == WAIT_LAST) begin
               bits_d[slot_q] = 1'b0;
               err_d          = 1'b1;
               advance        = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end

            if (advance) begin
               if (slot_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  slot_d  = slot_q + 1'b1;
                  state_d = S_ISSUE;
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready    = (state_q == S_LOAD);
   assign bus.seg_start   = (state_q == S_ISSUE);
   assign bus.seg_index   = 4'(slot_q);
   assign bus.seg_data    = buf_q[slot_q];
   assign bus.frame_bits  = bits_q;
   assign bus.frame_valid = (state_q == S_DONE);
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_demod_frame_scheduler.sv
// tb/tb_demod_frame_scheduler.sv - self-checking bench for demod_frame_scheduler
module tb_demod_frame_scheduler;

   localparam int NSEG    = 10;
   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   demod_frame_scheduler_if #(.NSEG(NSEG), .WIDTH(WIDTH)) bus ();

   demod_frame_scheduler #(
      .NSEG(NSEG),
      .WIDTH(WIDTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int fv_count  = 0;
   int start_cyc = 0;
   int fv_cyc    = 0;

   logic [31:0] samp [NSEG];
   logic [31:0] resp [NSEG];
   int          lat  [NSEG];   // 0 = segment never answers this slot

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.frame_valid === 1'b1) fv_count <= fv_count + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},    32'(bus.in_ready),    32'd0);
      chk({tag, "_seg_start"},   32'(bus.seg_start),   32'd0);
      chk({tag, "_seg_index"},   32'(bus.seg_index),   32'd0);
      chk({tag, "_seg_data"},    bus.seg_data,         32'd0);
      chk({tag, "_frame_bits"},  32'(bus.frame_bits),  32'd0);
      chk({tag, "_frame_valid"}, 32'(bus.frame_valid), 32'd0);
      chk({tag, "_busy"},        32'(bus.busy),        32'd0);
      chk({tag, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
   endtask

   task automatic rand_frame(input int maxlat);
      for (int k = 0; k < NSEG; k++) begin
         samp[k] = $urandom;
         resp[k] = samp[k];
         lat[k]  = $urandom_range(maxlat, 1);
      end
   endtask

   // Drives one frame: gap=1 toggles in_valid, spur=1 injects ignored start/seg_valid,
   // abort_slot>=0 resets in WAIT of that slot.
   task automatic run_frame(input int gap, input bit spur, input int abort_slot,
                            output logic [NSEG-1:0] bits_out);
      logic [NSEG-1:0] eb;
      bit              ee;
      bit              rdy_ok;
      int              t, last_t, exp_c, n, fv0, k, i;

      eb = '0;
      ee = 1'b0;
      for (int s = 0; s < NSEG; s++) begin
         if (lat[s] == 0) begin
            eb[s] = 1'b0;
            ee    = 1'b1;
         end else begin
            eb[s] = ~resp[s][31];
         end
      end
      bits_out = '0;
      fv0      = fv_count;
      last_t   = 0;

      bus.start = 1'b1;
      t         = cyc;
      start_cyc = t;
      step;
      bus.start = 1'b0;
      chk("start_busy",     32'(bus.busy),        32'd1);
      chk("start_in_ready", 32'(bus.in_ready),    32'd1);
      chk("start_err_clr",  32'(bus.timeout_err), 32'd0);
      chk("start_bits_clr", 32'(bus.frame_bits),  32'd0);

      k      = 0;
      i      = 0;
      rdy_ok = 1'b1;
      while (k < NSEG) begin
         if (bus.in_ready !== 1'b1) rdy_ok = 1'b0;
         if (gap == 0 || (i % 2) == 0) begin
            bus.in_valid = 1'b1;
            bus.in_data  = samp[k];
            last_t       = cyc;
            k++;
         end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = $urandom;
         end
         i++;
         step;
      end
      // Junk beat outside LOAD must not be captured.
      bus.in_valid = 1'b1;
      bus.in_data  = 32'hDEADBEEF;
      chk("in_ready_load",  32'(rdy_ok),       32'd1);
      chk("in_ready_after", 32'(bus.in_ready), 32'd0);

      exp_c = last_t + 1;
      for (int s = 0; s < NSEG; s++) begin
         n = 0;
         while (bus.seg_start !== 1'b1 && n < TIMEOUT + 4) begin
            step;
            bus.in_valid = 1'b0;
            n++;
         end
         chk("seg_start_seen", 32'(bus.seg_start), 32'd1);
         if (bus.seg_start !== 1'b1) begin
            bus.in_valid = 1'b0;
            return;
         end
         chk("seg_start_cycle", 32'(cyc),           32'(exp_c));
         chk("seg_index",       32'(bus.seg_index), 32'(s));
         chk("seg_data",        bus.seg_data,       samp[s]);
         exp_c += (lat[s] == 0) ? (TIMEOUT + 1) : (lat[s] + 1);

         if (spur) begin
            bus.seg_valid  = 1'b1;
            bus.seg_result = ~resp[s];
         end
         step;
         bus.in_valid  = 1'b0;
         bus.seg_valid = 1'b0;

         if (s == abort_slot) begin
            reset = 1'b1;
            step;
            reset = 1'b0;
            check_reset_vals("mid_reset");
            repeat (TIMEOUT + NSEG) step;
            chk("abort_no_fv",   32'(fv_count - fv0), 32'd0);
            chk("abort_idle",    32'(bus.busy),       32'd0);
            return;
         end

         if (spur && s == 3) bus.start = 1'b1;
         if (lat[s] != 0) begin
            for (int j = 1; j < lat[s]; j++) begin
               step;
               bus.start = 1'b0;
            end
            bus.seg_valid  = 1'b1;
            bus.seg_result = resp[s];
            step;
            bus.start     = 1'b0;
            bus.seg_valid = 1'b0;
         end else begin
            step;
            bus.start = 1'b0;
         end
      end

      n = 0;
      while (bus.frame_valid !== 1'b1 && n < TIMEOUT + 4) begin
         step;
         n++;
      end
      fv_cyc = cyc;
      chk("frame_valid",       32'(bus.frame_valid), 32'd1);
      chk("frame_valid_cycle", 32'(cyc),             32'(exp_c));
      chk("frame_bits",        32'(bus.frame_bits),  32'(eb));
      chk("timeout_err",       32'(bus.timeout_err), 32'(ee));
      bits_out = bus.frame_bits;
      step;
      chk("frame_valid_pulse", 32'(bus.frame_valid), 32'd0);
      chk("idle_after_done",   32'(bus.busy),        32'd0);
      chk("one_frame",         32'(fv_count - fv0),  32'd1);
   endtask

   logic [NSEG-1:0] b;
   int              fvb;

   initial begin
      reset          = 1'b1;
      bus.start      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_data    = '0;
      bus.seg_valid  = 1'b0;
      bus.seg_result = '0;
      repeat (3) step;
      check_reset_vals("reset");
      reset = 1'b0;
      step;

      // Alternating +1.0/-1.0 frame, echo latency 2.
      for (int k = 0; k < NSEG; k++) begin
         samp[k] = ((k % 2) == 0) ? 32'h00010000 : 32'hFFFF0000;
         resp[k] = samp[k];
         lat[k]  = 2;
      end
      run_frame(0, 1'b0, -1, b);
      chk("alt_bits",    32'(b),                32'(10'b0101010101));
      chk("alt_latency", 32'(fv_cyc - start_cyc), 32'd41);
      repeat (5) step;
      chk("bits_hold",   32'(bus.frame_bits),   32'(10'b0101010101));

      // Stalled loading gives the same result.
      run_frame(1, 1'b0, -1, b);
      chk("stall_bits",  32'(b),                32'(10'b0101010101));

      // Slot 4 never answered.
      rand_frame(4);
      lat[4] = 0;
      run_frame(0, 1'b0, -1, b);
      chk("timeout_bit4", 32'(b[4]), 32'd0);
      repeat (3) step;
      chk("timeout_sticky", 32'(bus.timeout_err), 32'd1);

      // Next start clears the error.
      rand_frame(3);
      run_frame(0, 1'b0, -1, b);

      // Spurious seg_valid in IDLE, then a frame with spurious start/seg_valid.
      fvb = fv_count;
      bus.seg_valid  = 1'b1;
      bus.seg_result = 32'h80000000;
      step;
      bus.seg_valid  = 1'b0;
      step;
      chk("idle_seg_valid_busy", 32'(bus.busy),       32'd0);
      chk("idle_seg_valid_fv",   32'(fv_count - fvb), 32'd0);
      rand_frame(4);
      run_frame(0, 1'b1, -1, b);

      // Reset in WAIT of slot 6, then a normal frame.
      rand_frame(3);
      run_frame(0, 1'b0, 6, b);
      rand_frame(3);
      run_frame(1, 1'b0, -1, b);

      // Boundary results and result/timeout coincidence.
      rand_frame(4);
      resp[0] = 32'h00000000;
      resp[1] = 32'h80000000;
      lat[2]  = TIMEOUT;
      run_frame(0, 1'b0, -1, b);
      chk("zero_is_one",   32'(b[0]), 32'd1);
      chk("minneg_is_zero", 32'(b[1]), 32'd0);

      // Random frames with occasional silent slots.
      for (int r = 0; r < 3; r++) begin
         rand_frame(6);
         for (int k = 0; k < NSEG; k++) begin
            if ($urandom_range(7, 0) == 0) lat[k] = 0;
            if ($urandom_range(3, 0) == 0) resp[k] = $urandom;
         end
         run_frame(r % 2, 1'b0, -1, b);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/demod_frame_scheduler.md
# demod_frame_scheduler

Sequences one frame of ten Q16.16 soft samples through the shared demodulation-segment datapath, one segment slot at a time. It buffers the frame, issues each sample to its segment with the matching slot index, waits for the segment result, and slices the result into a hard bit. The block sits between the sample source and the segment array, and presents a packed 10-bit frame word to the downstream bit sink.

## Interface
Parameters:
- NSEG, 10, segments (and samples) per frame; 2..16.
- WIDTH, 32, sample/result width, Q16.16 two's complement.
- TIMEOUT, 15, max cycles to wait for seg_valid after seg_start; ≥ 3.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset, as already decided for this block.
- start  in  1  frame request pulse; sampled only in IDLE.
- in_valid  in  1  sample strobe.
- in_data  in  WIDTH  sample.
- in_ready  out  1  high in LOAD only.
- seg_start  out  1  one-cycle issue pulse to the segment datapath.
- seg_index  out  4  slot being issued/awaited, 0..NSEG-1.
- seg_data  out  WIDTH  sample for seg_index; held stable through WAIT.
- seg_result  in  WIDTH  segment output (±1.0 = 0x00010000 / 0xFFFF0000).
- seg_valid  in  1  seg_result qualifier.
- frame_bits  out  NSEG  bit k = decision of segment k.
- frame_valid  out  1  one-cycle pulse, frame_bits valid.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set on any slot timeout, cleared by the next accepted start.

## Operation
- Reset values: in_ready=0, seg_start=0, seg_index=0, seg_data=0, frame_bits=0, frame_valid=0, busy=0, timeout_err=0. State = IDLE. Sample buffer and counters = 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT, DONE.
- IDLE: when start=1, go to LOAD, clear load counter, clear timeout_err, clear frame_bits.
- LOAD: each cycle with in_valid=1 writes in_data to buffer[cnt]; cnt++. After the NSEG-th write, go to ISSUE with slot=0. in_valid outside LOAD is ignored.
- ISSUE: assert seg_start for exactly one cycle with seg_index=slot and seg_data=buffer[slot]. Go to WAIT and clear the wait counter.
- WAIT: seg_valid=1 means the decision frame_bits[slot] = ~seg_result[WIDTH-1]. A sign bit of 0 gives 1; zero counts as positive.
  - Wait-counter reaching TIMEOUT without seg_valid: frame_bits[slot]=0, timeout_err=1.
  - On either event: if slot=NSEG-1, go to DONE; else slot++ and go to ISSUE.
  - If seg_valid and timeout coincide, the result wins and no error is raised.
- DONE: frame_valid=1 for one cycle, then go to IDLE. frame_bits holds until the next accepted start.
- Ignored events:
  - start outside IDLE, with no queuing.
  - seg_valid outside WAIT, including in the seg_start cycle.
- Reset mid-operation: immediately go to IDLE with all reset values. A partial frame is discarded and no frame_valid is produced.

## Timing
- start at cycle t: busy=1 and in_ready=1 from t+1.
- Zero-gap input: the last sample is written at t+NSEG. seg_start for slot 0 is at t+NSEG+1.
- Segment latency L (cycles from seg_start to seg_valid, L≥1): each slot costs L+1 cycles. The next seg_start comes 1 cycle after seg_valid.
- Frame latency with L=2 and NSEG=10: start at t gives frame_valid at t+10+30+1 = t+41. busy drops at t+42.
- Timeout slot: cost is TIMEOUT+1 cycles.
- Back-to-back: start is accepted the cycle after frame_valid at the earliest, since IDLE is reached then.

## Test plan
- Alternating frame: samples +1.0,-1.0,… (0x00010000/0xFFFF0000), segment model echoes sample with L=2.
  - frame_bits=10'b0101010101 (bit0=1), frame_valid at t+41, timeout_err=0.
- Stalled loading: in_valid toggles every other cycle.
  - Exactly 10 samples captured, in_ready drops after the 10th.
  - Results are identical to the zero-gap case.
- Timeout: the model never answers slot 4.
  - After TIMEOUT cycles the scheduler advances, frame_bits[4]=0, timeout_err=1.
  - The remaining bits are correct.
  - The next start clears timeout_err.
- Spurious inputs:
  - start pulsed during WAIT, and seg_valid pulsed in IDLE and in the seg_start cycle.
  - No extra frame, and no bit corrupted.
- Reset mid-frame: reset asserted in WAIT of slot 6.
  - Next cycle all outputs are at reset values and no frame_valid is produced.
  - A new frame completes normally.
- Boundary result: seg_result=0 and seg_result=0x80000000.
  - Bits 1 and 0 respectively.
  - seg_valid coinciding with timeout gives no error.
